// File: rtl/microcode_loader.sv
// microcode_loader: after reset (or on request from DONE/ERROR) writes the
// built-in decode table into the core's microcode store, optionally reads it
// back and compares, and holds the core in reset until the table is good.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  single-cycle reload request (honoured in DONE/ERROR)
//   microcode_we_o           store write strobe
//   microcode_write_addr_o   store write address
//   microcode_write_data_o   store write data
//   microcode_read_addr_o    store readback address
//   microcode_read_data_i    store readback data, one cycle after the address
//   core_rst_o               active-high hold-in-reset for the core
//   done_o                   table loaded (and verified)
//   error_o                  readback mismatch seen
//   error_addr_o             first mismatching address
module microcode_loader #(
   parameter int unsigned NUM_ENTRIES = 39,
   parameter int unsigned VERIFY_EN   = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   output logic        microcode_we_o,
   output logic [5:0]  microcode_write_addr_o,
   output logic [18:0] microcode_write_data_o,
   output logic [5:0]  microcode_read_addr_o,
   input  logic [18:0] microcode_read_data_i,
   output logic        core_rst_o,
   output logic        done_o,
   output logic        error_o,
   output logic [5:0]  error_addr_o
);

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 19;
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ENTRIES - 1);

   // Field encodings
   localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2,
                          IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;
   localparam logic [1:0] DW_B = 2'd0, DW_H = 2'd1, DW_W = 2'd2;
   localparam logic [1:0] RD_ALU = 2'd0, RD_MEM = 2'd1, RD_PC4 = 2'd2;
   localparam logic [1:0] BC_NONE = 2'd0, BC_ALWAYS = 2'd1, BC_ZERO = 2'd2, BC_NZ = 2'd3;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                          OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                          OP_OR = 4'd8, OP_AND = 4'd9, OP_PASSB = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_VERIFY, S_DONE, S_ERROR
   } state_e;

   // Pack one decode word from its fields
   function automatic logic [DW-1:0] uc_word(
      input logic [2:0] imm_sel, input logic [1:0] datawidth, input logic sign_ext,
      input logic lsu_we, input logic [1:0] rd_sel, input logic rf_we, input logic br_base,
      input logic [1:0] br_cond, input logic [3:0] alu_op, input logic b_sel, input logic a_sel);
      return {imm_sel, datawidth, sign_ext, lsu_we, rd_sel, rf_we, br_base, br_cond,
              alu_op, b_sel, a_sel};
   endfunction

   // Decode table, one slot per RV32I opcode; unused slots read as 0
   function automatic logic [DW-1:0] uc_table(input logic [AW-1:0] a);
      logic [DW-1:0] w;
      w = '0;
      case (a)
         6'd0:  w = uc_word(IMM_U, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_PASSB, 1'b1, 1'b0); // LUI
         6'd1:  w = uc_word(IMM_U, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b1); // AUIPC
         6'd2:  w = uc_word(IMM_J, DW_B, 1'b0, 1'b0, RD_PC4, 1'b1, 1'b0, BC_ALWAYS, OP_ADD, 1'b0, 1'b0); // JAL
         6'd3:  w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_PC4, 1'b1, 1'b1, BC_ALWAYS, OP_ADD, 1'b0, 1'b0); // JALR
         6'd4:  w = uc_word(IMM_B, DW_B, 1'b0, 1'b0, RD_ALU, 1'b0, 1'b0, BC_ZERO, OP_SUB,   1'b0, 1'b0); // BEQ
         6'd5:  w = uc_word(IMM_B, DW_B, 1'b0, 1'b0, RD_ALU, 1'b0, 1'b0, BC_NZ,   OP_SUB,   1'b0, 1'b0); // BNE
         6'd6:  w = uc_word(IMM_B, DW_B, 1'b0, 1'b0, RD_ALU, 1'b0, 1'b0, BC_NZ,   OP_SLT,   1'b0, 1'b0); // BLT
         6'd7:  w = uc_word(IMM_B, DW_B, 1'b0, 1'b0, RD_ALU, 1'b0, 1'b0, BC_ZERO, OP_SLT,   1'b0, 1'b0); // BGE
         6'd8:  w = uc_word(IMM_B, DW_B, 1'b0, 1'b0, RD_ALU, 1'b0, 1'b0, BC_NZ,   OP_SLTU,  1'b0, 1'b0); // BLTU
         6'd9:  w = uc_word(IMM_B, DW_B, 1'b0, 1'b0, RD_ALU, 1'b0, 1'b0, BC_ZERO, OP_SLTU,  1'b0, 1'b0); // BGEU
         6'd10: w = uc_word(IMM_I, DW_B, 1'b1, 1'b0, RD_MEM, 1'b1, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b0); // LB
         6'd11: w = uc_word(IMM_I, DW_H, 1'b1, 1'b0, RD_MEM, 1'b1, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b0); // LH
         6'd12: w = uc_word(IMM_I, DW_W, 1'b0, 1'b0, RD_MEM, 1'b1, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b0); // LW
         6'd13: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_MEM, 1'b1, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b0); // LBU
         6'd14: w = uc_word(IMM_I, DW_H, 1'b0, 1'b0, RD_MEM, 1'b1, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b0); // LHU
         6'd15: w = uc_word(IMM_S, DW_B, 1'b0, 1'b1, RD_ALU, 1'b0, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b0); // SB
         6'd16: w = uc_word(IMM_S, DW_H, 1'b0, 1'b1, RD_ALU, 1'b0, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b0); // SH
         6'd17: w = uc_word(IMM_S, DW_W, 1'b0, 1'b1, RD_ALU, 1'b0, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b0); // SW
         6'd18: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_ADD,   1'b1, 1'b0); // ADDI
         6'd19: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SLT,   1'b1, 1'b0); // SLTI
         6'd20: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SLTU,  1'b1, 1'b0); // SLTIU
         6'd21: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_XOR,   1'b1, 1'b0); // XORI
         6'd22: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_OR,    1'b1, 1'b0); // ORI
         6'd23: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_AND,   1'b1, 1'b0); // ANDI
         6'd24: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SLL,   1'b1, 1'b0); // SLLI
         6'd25: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SRL,   1'b1, 1'b0); // SRLI
         6'd26: w = uc_word(IMM_I, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SRA,   1'b1, 1'b0); // SRAI
         6'd27: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_ADD,  1'b0, 1'b0); // ADD
         6'd28: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SUB,  1'b0, 1'b0); // SUB
         6'd29: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SLL,  1'b0, 1'b0); // SLL
         6'd30: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SLT,  1'b0, 1'b0); // SLT
         6'd31: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SLTU, 1'b0, 1'b0); // SLTU
         6'd32: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_XOR,  1'b0, 1'b0); // XOR
         6'd33: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SRL,  1'b0, 1'b0); // SRL
         6'd34: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_SRA,  1'b0, 1'b0); // SRA
         6'd35: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_OR,   1'b0, 1'b0); // OR
         6'd36: w = uc_word(IMM_NONE, DW_B, 1'b0, 1'b0, RD_ALU, 1'b1, 1'b0, BC_NONE, OP_AND,  1'b0, 1'b0); // AND
         default: w = '0;  // FENCE, ECALL/EBREAK and unused slots
      endcase
      return w;
   endfunction

   state_e          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic            tail_q, tail_d;     // compare-only cycle at the end of VERIFY
   logic [AW-1:0]   err_addr_q, err_addr_d;
   logic            we_d, core_rst_d, done_d, error_d;
   logic [AW-1:0]   waddr_d, raddr_d;
   logic [DW-1:0]   wdata_d;
   logic [AW-1:0]   cmp_addr;
   logic            cmp_en, mismatch;

   // Readback data lags the issued address by one cycle
   assign cmp_addr = tail_q ? LAST_IDX : (idx_q - 6'd1);
   assign cmp_en   = (state_q == S_VERIFY) && (tail_q || (idx_q != '0));
   assign mismatch = cmp_en && (microcode_read_data_i != uc_table(cmp_addr));

   // State register; outputs are registered from the next-state decode
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q                <= S_IDLE;
         idx_q                  <= '0;
         tail_q                 <= 1'b0;
         err_addr_q             <= '0;
         microcode_we_o         <= 1'b0;
         microcode_write_addr_o <= '0;
         microcode_write_data_o <= '0;
         microcode_read_addr_o  <= '0;
         core_rst_o             <= 1'b1;
         done_o                 <= 1'b0;
         error_o                <= 1'b0;
      end else begin
         state_q                <= state_d;
         idx_q                  <= idx_d;
         tail_q                 <= tail_d;
         err_addr_q             <= err_addr_d;
         microcode_we_o         <= we_d;
         microcode_write_addr_o <= waddr_d;
         microcode_write_data_o <= wdata_d;
         microcode_read_addr_o  <= raddr_d;
         core_rst_o             <= core_rst_d;
         done_o                 <= done_d;
         error_o                <= error_d;
      end
   end

   assign error_addr_o = err_addr_q;

   // Next-state and index sequencing
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tail_d     = tail_q;
      err_addr_d = err_addr_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_WRITE;
            idx_d   = '0;
         end
         S_WRITE: begin
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = (VERIFY_EN != 0) ? S_VERIFY : S_DONE;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_VERIFY: begin
            if (mismatch) begin
               state_d    = S_ERROR;
               err_addr_d = cmp_addr;
               idx_d      = '0;
               tail_d     = 1'b0;
            end else if (tail_q) begin
               state_d = S_DONE;
               idx_d   = '0;
               tail_d  = 1'b0;
            end else if (idx_q == LAST_IDX) begin
               tail_d = 1'b1;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_DONE, S_ERROR: begin
            if (start_i) begin
               state_d    = S_WRITE;
               idx_d      = '0;
               err_addr_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            tail_d  = 1'b0;
         end
      endcase
   end

   // Output decode of the upcoming state
   always_comb begin
      we_d       = 1'b0;
      waddr_d    = '0;
      wdata_d    = '0;
      raddr_d    = '0;
      core_rst_d = 1'b1;
      done_d     = 1'b0;
      error_d    = 1'b0;
      case (state_d)
         S_WRITE: begin
            we_d    = 1'b1;
            waddr_d = idx_d;
            wdata_d = uc_table(idx_d);
         end
         S_VERIFY: begin
            if (!tail_d) raddr_d = idx_d;
         end
         S_DONE: begin
            core_rst_d = 1'b0;
            done_d     = 1'b1;
         end
         S_ERROR: error_d = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_microcode_loader.sv
// Bench for microcode_loader: a verifying instance on a model store with
// injectable readback corruption, plus a VERIFY_EN=0 instance on the same
// reset. Expectations come from a cycle-position model of each load.
module tb_microcode_loader;

   localparam int N = 39;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_ni, start_i;
   logic        we, we2, crst, crst2, dn, dn2, er, er2;
   logic [5:0]  wa, wa2, ra, ra2, ea, ea2;
   logic [18:0] wd, wd2, rd;

   microcode_loader u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
      .microcode_we_o(we), .microcode_write_addr_o(wa), .microcode_write_data_o(wd),
      .microcode_read_addr_o(ra), .microcode_read_data_i(rd),
      .core_rst_o(crst), .done_o(dn), .error_o(er), .error_addr_o(ea)
   );

   microcode_loader #(.NUM_ENTRIES(39), .VERIFY_EN(0)) u_dut_nv (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(1'b0),
      .microcode_we_o(we2), .microcode_write_addr_o(wa2), .microcode_write_data_o(wd2),
      .microcode_read_addr_o(ra2), .microcode_read_data_i(19'd0),
      .core_rst_o(crst2), .done_o(dn2), .error_o(er2), .error_addr_o(ea2)
   );

   // Model store: 1-cycle read latency, per-address readback corruption
   logic [18:0] mem [64];
   logic [18:0] corrupt [64];
   always @(posedge clk) begin
      if (we) mem[wa] <= wd;
      rd <= mem[ra] ^ corrupt[ra];
   end

   int n_checks, n_errs;
   int t;       // cycle position in current load of u_dut (0 = IDLE, 1..N = writes)
   int t2;      // same for u_dut_nv
   int err_at;  // expected first failing address of current load, -1 = none

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Table word from its fields by bit position
   function automatic logic [18:0] fw(int imm, int dw, int sx, int lwe, int rds, int rfwe,
                                       int bbs, int bc, int op, int bs, int as);
      return 19'((imm << 16) | (dw << 14) | (sx << 13) | (lwe << 12) | (rds << 10) |
                 (rfwe << 9) | (bbs << 8) | (bc << 6) | (op << 2) | (bs << 1) | as);
   endfunction

   function automatic logic [18:0] exp_word(int a);
      int iops [9] = '{0, 3, 4, 5, 8, 9, 2, 6, 7};
      case (a)
         0:  return fw(4, 0, 0, 0, 0, 1, 0, 0, 10, 1, 0);
         1:  return fw(4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
         2:  return fw(5, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0);
         3:  return fw(1, 0, 0, 0, 2, 1, 1, 1, 0, 0, 0);
         4:  return fw(3, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
         5:  return fw(3, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
         6:  return fw(3, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
         7:  return fw(3, 0, 0, 0, 0, 0, 0, 2, 3, 0, 0);
         8:  return fw(3, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0);
         9:  return fw(3, 0, 0, 0, 0, 0, 0, 2, 4, 0, 0);
         10: return fw(1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0);
         11: return fw(1, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0);
         12: return fw(1, 2, 0, 0, 1, 1, 0, 0, 0, 1, 0);
         13: return fw(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
         14: return fw(1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0);
         15: return fw(2, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
         16: return fw(2, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
         17: return fw(2, 2, 0, 1, 0, 0, 0, 0, 0, 1, 0);
         default: begin
            if (a >= 18 && a <= 26) return fw(1, 0, 0, 0, 0, 1, 0, 0, iops[a-18], 1, 0);
            if (a >= 27 && a <= 36) return fw(0, 0, 0, 0, 0, 1, 0, 0, a - 27, 0, 0);
            return 19'd0;
         end
      endcase
   endfunction

   function automatic logic [63:0] wr_pack(int a);
      return (64'h1 << 25) | (64'(a) << 19) | 64'(exp_word(a));
   endfunction

   function automatic int first_err();
      for (int a = 0; a < N; a++) if (corrupt[a] != 19'd0) return a;
      return -1;
   endfunction

   // Last cycle position that belongs to VERIFY
   function automatic int vend();
      return (err_at >= 0) ? (N + err_at + 2) : (2 * N + 1);
   endfunction

   function automatic logic [18:0] rand_mask();
      return 19'($urandom_range(1, 19'h7FFFF));
   endfunction

   task automatic check_cycle();
      logic [63:0] ew, eradr, est;
      ew = 64'h0; eradr = 64'h0; est = 64'h100;
      if (t >= 1 && t <= N) ew = wr_pack(t - 1);
      else if (t > N && t <= vend()) begin
         if (t <= 2 * N) eradr = 64'(t - N - 1);
      end else if (t > vend()) begin
         est = (err_at >= 0) ? (64'h140 | 64'(err_at)) : 64'h80;
      end
      check("wr_port", 64'({we, wa, wd}), ew);
      check("rd_addr", 64'(ra), eradr);
      check("status", 64'({crst, dn, er, ea}), est);
      ew = (t2 >= 1 && t2 <= N) ? wr_pack(t2 - 1) : 64'h0;
      check("nv_wr_port", 64'({we2, wa2, wd2}), ew);
      check("nv_rd_addr", 64'(ra2), 64'h0);
      check("nv_status", 64'({crst2, dn2, er2, ea2}), (t2 > N) ? 64'h80 : 64'h100);
   endtask

   task automatic advance(input logic st);
      if (!rst_ni) begin
         t = 0; t2 = 0; err_at = first_err();
      end else begin
         if (st && t > vend()) begin
            t = 1; err_at = first_err();
         end else begin
            t++;
         end
         t2++;
      end
   endtask

   // One clock cycle: drive start, check at negedge, advance model after posedge
   task automatic step(input logic st, output logic d1, output logic d2);
      start_i = st;
      @(negedge clk);
      check_cycle();
      d1 = dn; d2 = dn2;
      @(posedge clk); #1;
      advance(st);
      start_i = 1'b0;
   endtask

   function automatic logic busy_start();
      return (t <= vend()) && ($urandom_range(0, 11) == 0);
   endfunction

   task automatic check_store(input string tag);
      int bad;
      bad = 0;
      for (int a = 0; a < N; a++) if (mem[a] !== exp_word(a)) bad++;
      check(tag, 64'(bad), 64'd0);
   endtask

   initial begin
      logic d1, d2;
      int   first1, first2, k;
      n_checks = 0; n_errs = 0;
      t = 0; t2 = 0; err_at = -1;
      rst_ni = 1'b0; start_i = 1'b0;
      for (int i = 0; i < 64; i++) corrupt[i] = 19'd0;
      @(posedge clk); #1;
      repeat (3) step(1'b1, d1, d2);

      // Nominal load from reset; a start at write index 5 must be ignored
      rst_ni = 1'b1;
      first1 = -1; first2 = -1;
      for (int c = 0; c < 2 * N + 8; c++) begin
         step(c == 6, d1, d2);
         if (d1 && first1 < 0) first1 = c;
         if (d2 && first2 < 0) first2 = c;
      end
      check("done_cycle", 64'(first1), 64'd80);
      check("nv_done_cycle", 64'(first2), 64'd40);
      check_store("store_img");

      // Reloads with assorted readback corruption
      for (int it = 0; it < 7; it++) begin
         for (int i = 0; i < 64; i++) corrupt[i] = 19'd0;
         case (it)
            0: corrupt[17] = 19'h1;
            1: corrupt[0] = rand_mask();
            2: corrupt[N-1] = rand_mask();
            3: ;
            default: if ($urandom_range(0, 1) == 1) begin
               corrupt[$urandom_range(0, N - 1)] = rand_mask();
               corrupt[$urandom_range(0, N - 1)] = rand_mask();
            end
         endcase
         repeat ($urandom_range(1, 4)) step(1'b0, d1, d2);
         step(1'b1, d1, d2);
         k = -1;
         for (int c = 1; c < 2 * N + 6; c++) begin
            step(busy_start(), d1, d2);
            if (d1 && k < 0) k = c;
         end
         if (err_at < 0) check("reload_latency", 64'(k - 1), 64'd79);
         check_store("reload_store_img");
      end

      // Reset asserted at write index 20 of a reload
      for (int i = 0; i < 64; i++) corrupt[i] = 19'd0;
      step(1'b1, d1, d2);
      for (int c = 0; c < 40 && t != 21; c++) step(1'b0, d1, d2);
      check("abort_point", 64'(wa), 64'd20);
      rst_ni = 1'b0;
      #1;
      t = 0; t2 = 0; err_at = first_err();
      check_cycle();
      repeat (2) step(1'b0, d1, d2);
      rst_ni = 1'b1;
      first1 = -1;
      for (int c = 0; c < 2 * N + 8; c++) begin
         step(busy_start(), d1, d2);
         if (d1 && first1 < 0) first1 = c;
      end
      check("reset_reload_done", 64'(first1), 64'd80);
      check_store("reset_store_img");

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
